mdu_sequencer: RTL and testbench

- Multi-cycle multiply/divide controller for the EX stage of the pipelined MIPS core (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
- Holds the architectural HI/LO registers.
- Owns no adder: drives the shared 32-bit ALU (operands, opCode) every busy cycle and consumes its result. Iterates shift-add multiply and restoring divide.
- Asserts busy so the hazard logic stalls the pipeline.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/alu.sv | 27 ++
 rtl/mdu_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared EX-stage definitions: ALU opcodes, multiply/divide op encodings and
// the multiply/divide sequencer state set.
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam int ITERS = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NEG_A = 3'd1,
    NEG_B = 3'd2,
    ITER  = 3'd3,
    FIX0  = 3'd4,
    FIX1  = 3'd5,
    FIX2  = 3'd6,
    DONE  = 3'd7
  } mdu_state_e;

endpackage

// File: rtl/alu.sv
// 32-bit EX-stage ALU shared by the datapath and the multiply/divide sequencer.
// Purely combinational; the result is valid in the same cycle.
module alu
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  opCode,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (opCode)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
      ALU_SLT: result = {31'b0, $signed(a) < $signed(b)};
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer holding HI/LO. It has no adder of
// its own: every busy cycle it drives the shared ALU and consumes its result.
module mdu_sequencer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  mduOp,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        hiWe,
  input  logic        loWe,
  input  logic [31:0] wrData,
  output logic        busy,
  output logic        done,
  output logic        divByZero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] aluIn1,
  output logic [31:0] aluIn2,
  output logic [3:0]  aluOpCode,
  input  logic [31:0] aluResult
);

  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

  mdu_state_e state, stateNext;
  logic [CNT_W-1:0] count;

  logic        isDiv, signA, signB, dbz, loZero;
  logic [31:0] aReg, bReg, magA, magB, tmp;

  logic [31:0] sHi, iterHi, iterLo;
  logic        carry, borrow, negLo, negHi;

  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);
  assign divByZero = (state == DONE) && dbz;

  assign negLo = signA ^ signB;
  assign negHi = isDiv ? signA : (signA ^ signB);

  // Divide step shifts {rem,quot} left by one; the bit leaving rem is bit 32.
  assign sHi = {hi[30:0], lo[31]};

  // Carry/borrow recovered from operand and result MSBs since the ALU has no carry out.
  assign carry  = (aluIn1[31] & aluIn2[31]) |
                  ((aluIn1[31] | aluIn2[31]) & ~aluResult[31]);
  assign borrow = (~aluIn1[31] & aluIn2[31]) |
                  ((~aluIn1[31] | aluIn2[31]) & aluResult[31]);

  always_comb begin
    stateNext = state;
    aluIn1    = '0;
    aluIn2    = '0;
    aluOpCode = ALU_AND;
    case (state)
      IDLE: begin
        if (start) stateNext = NEG_A;
      end
      NEG_A: begin
        aluOpCode = ALU_SUB;
        aluIn2    = aReg;
        stateNext = NEG_B;
      end
      NEG_B: begin
        aluOpCode = ALU_SUB;
        aluIn2    = bReg;
        stateNext = ITER;
      end
      ITER: begin
        if (isDiv) begin
          aluOpCode = ALU_SUB;
          aluIn1    = sHi;
          aluIn2    = magB;
        end else begin
          aluOpCode = ALU_ADD;
          aluIn1    = hi;
          aluIn2    = lo[0] ? magB : '0;
        end
        if (count == LAST) stateNext = FIX0;
      end
      FIX0: begin
        aluOpCode = ALU_SUB;
        aluIn2    = lo;
        stateNext = FIX1;
      end
      FIX1: begin
        aluOpCode = ALU_NOR;
        aluIn1    = hi;
        aluIn2    = hi;
        stateNext = FIX2;
      end
      FIX2: begin
        aluOpCode = ALU_ADD;
        aluIn1    = tmp;
        aluIn2    = {31'b0, isDiv ? 1'b1 : loZero};
        stateNext = DONE;
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    iterHi = hi;
    iterLo = lo;
    if (isDiv) begin
      if (hi[31] | ~borrow) begin
        iterHi = aluResult;
        iterLo = {lo[30:0], 1'b1};
      end else begin
        iterHi = sHi;
        iterLo = {lo[30:0], 1'b0};
      end
    end else begin
      iterHi = {carry, aluResult[31:1]};
      iterLo = {aluResult[0], lo[31:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (hiWe) hi <= wrData;
          if (loWe) lo <= wrData;
        end
        NEG_B: begin
          hi    <= '0;
          lo    <= magA;
          count <= '0;
        end
        ITER: begin
          hi    <= iterHi;
          lo    <= iterLo;
          count <= count + 1'b1;
        end
        FIX0: begin
          if (negLo && !dbz) lo <= aluResult;
        end
        FIX2: begin
          // Divide by zero leaves the untouched dividend in HI.
          if (dbz)        hi <= aReg;
          else if (negHi) hi <= aluResult;
        end
        default: ;
      endcase
    end
  end

  // Operand and scratch state; only meaningful while an operation is in flight.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          isDiv <= mduOp[1];
          aReg  <= rs;
          bReg  <= rt;
          signA <= ~mduOp[0] & rs[31];
          signB <= ~mduOp[0] & rt[31];
          dbz   <= mduOp[1] & (rt == '0);
        end
      end
      NEG_A: magA <= signA ? aluResult : aReg;
      NEG_B: magB <= signB ? aluResult : bReg;
      ITER: begin
        if (count == LAST) loZero <= (iterLo == '0);
      end
      FIX1: tmp <= aluResult;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer with the shared ALU beside it.
module tb_mdu_sequencer;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mduOp;
  logic [31:0] rs, rt;
  logic        hiWe, loWe;
  logic [31:0] wrData;
  logic        busy, done, divByZero;
  logic [31:0] hi, lo;
  logic [31:0] aluIn1, aluIn2, aluResult;
  logic [3:0]  aluOpCode;

  int checks = 0;
  int passed = 0;

  mdu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mduOp(mduOp),
    .rs(rs), .rt(rt), .hiWe(hiWe), .loWe(loWe), .wrData(wrData),
    .busy(busy), .done(done), .divByZero(divByZero), .hi(hi), .lo(lo),
    .aluIn1(aluIn1), .aluIn2(aluIn2), .aluOpCode(aluOpCode),
    .aluResult(aluResult)
  );

  alu u_alu (
    .a(aluIn1), .b(aluIn2), .opCode(aluOpCode), .result(aluResult)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask

  // Issues one operation at the current cycle N; optionally pulses start+loWe
  // at cycle N+glitchAt to show they are ignored while busy.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expHi, input logic [31:0] expLo,
                        input logic expDbz, input int glitchAt);
    int   lat;
    logic seen;
    logic gap;
    mduOp = op; rs = a; rt = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rs = 32'h0; rt = 32'h0;
    lat = 1; seen = 1'b0; gap = 1'b0;
    chk({tag, "_busy1"}, busy, 1);
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (!busy) gap = 1'b1;
        if (lat == glitchAt) begin
          start = 1'b1; loWe = 1'b1; wrData = 32'hDEAD_BEEF;
          mduOp = MDU_DIVU; rs = 32'h99; rt = 32'h7;
        end
        @(posedge clk); #1;
        start = 1'b0; loWe = 1'b0;
        lat++;
      end
    end
    chk({tag, "_lat"}, lat, 38);
    chk({tag, "_gap"}, gap, 0);
    chk({tag, "_busyD"}, busy, 0);
    chk({tag, "_hi"}, hi, expHi);
    chk({tag, "_lo"}, lo, expLo);
    chk({tag, "_dbz"}, divByZero, expDbz);
    @(posedge clk); #1;
    chk({tag, "_doneoff"}, done, 0);
    chk({tag, "_hiHold"}, hi, expHi);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mduOp = 2'b00; rs = '0; rt = '0;
    hiWe = 1'b0; loWe = 1'b0; wrData = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", divByZero, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_alu1", aluIn1, 0);
    chk("rst_alu2", aluIn2, 0);
    chk("rst_aluop", {28'b0, aluOpCode}, {28'b0, ALU_AND});
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("multu_ff", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
    run_op("mult_m7x6", MDU_MULT, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, 0);
    run_op("mult_min2", MDU_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 0);
    run_op("div_m7d2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    run_op("divu_min3", MDU_DIVU, 32'h8000_0000, 32'd3, 32'h0000_0002, 32'h2AAA_AAAA, 1'b0, 0);
    run_op("div_5d0", MDU_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("div_m5d0", MDU_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 0);

    // MTLO / MTHI while idle
    loWe = 1'b1; wrData = 32'h0000_1234;
    @(posedge clk); #1;
    loWe = 1'b0;
    chk("mtlo", lo, 32'h0000_1234);
    hiWe = 1'b1; wrData = 32'hCAFE_0001;
    @(posedge clk); #1;
    hiWe = 1'b0;
    chk("mthi", hi, 32'hCAFE_0001);

    run_op("multu_3x4_glitch", MDU_MULTU, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 5);

    // Asynchronous reset in the middle of a divide
    mduOp = MDU_DIVU; rs = 32'd1000; rt = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_hi", hi, 0);
    chk("mid_lo", lo, 0);
    chk("mid_done", done, 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_done_hold", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", busy, 0);
    run_op("multu_2x3", MDU_MULTU, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
